// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, accepts out-of-order
// completions by index, and retires at most one entry per cycle from the head.
// A retiring entry can produce an RF write, a store commit, or a precise
// exception. An exception retire flushes the whole buffer.
module reorder_buffer #(
  parameter int ROB_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_allocate,
  input  logic [4:0]        in_alloc_rd,
  input  logic              in_alloc_is_store,
  input  logic [DATA_W-1:0] in_alloc_PC,
  output logic [IDX_W-1:0]  out_alloc_idx,
  output logic              out_full,
  input  logic              in_complete,
  input  logic [IDX_W-1:0]  in_complete_idx,
  input  logic [DATA_W-1:0] in_complete_data,
  input  logic [2:0]        in_complete_exception,
  input  logic              in_flush,
  output logic              out_write_enable,
  output logic [4:0]        out_write_reg,
  output logic [DATA_W-1:0] out_write_data,
  output logic              out_store_commit,
  output logic              out_exception,
  output logic [2:0]        out_exception_vector,
  output logic [DATA_W-1:0] out_exception_PC,
  output logic [IDX_W:0]    out_count
);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [4:0]        rd;
    logic              is_store;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [2:0]        exc;
  } entry_t;

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(ROB_ENTRIES);

  entry_t            rob_q [ROB_ENTRIES];
  entry_t            rob_d [ROB_ENTRIES];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  entry_t head_e;
  logic   full, alloc_acc, eligible, ret_norm, ret_exc, ret_wr, flush_all;

  // Retire decision is made purely on registered state, so a completion
  // written at an edge is visible to retirement only in the following cycle.
  always_comb begin
    head_e    = rob_q[head_q];
    full      = (count_q == FULL_CNT);
    // Full is judged before this cycle's retirement: a full buffer never
    // accepts, even while it retires.
    alloc_acc = in_allocate && !full && !in_flush;
    eligible  = head_e.valid && head_e.done;
    ret_norm  = eligible && (head_e.exc == 3'd0);
    ret_exc   = eligible && (head_e.exc != 3'd0);
    ret_wr    = ret_norm && !head_e.is_store;
    flush_all = in_flush || ret_exc;
  end

  // Retire-port and status outputs; retire data is zeroed whenever unused.
  always_comb begin
    out_alloc_idx        = tail_q;
    out_full             = full;
    out_count            = count_q;
    out_write_enable     = ret_wr && (head_e.rd != 5'd0);
    out_write_reg        = ret_wr ? head_e.rd : 5'd0;
    out_write_data       = ret_wr ? head_e.data : '0;
    out_store_commit     = ret_norm && head_e.is_store;
    out_exception        = ret_exc;
    out_exception_vector = ret_exc ? head_e.exc : 3'd0;
    out_exception_PC     = ret_exc ? head_e.pc : '0;
  end

  // Next-state: flush dominates; otherwise complete, retire and allocate.
  // Complete and allocate never hit the same slot: the tail slot is invalid
  // whenever an allocation can be accepted.
  always_comb begin
    for (int i = 0; i < ROB_ENTRIES; i++) rob_d[i] = rob_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_all) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        rob_d[i].valid = 1'b0;
        rob_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (in_complete && rob_q[in_complete_idx].valid) begin
        rob_d[in_complete_idx].done = 1'b1;
        rob_d[in_complete_idx].data = in_complete_data;
        rob_d[in_complete_idx].exc  = in_complete_exception;
      end
      if (ret_norm) begin
        rob_d[head_q].valid = 1'b0;
        rob_d[head_q].done  = 1'b0;
        head_d              = head_q + IDX_W'(1);
      end
      if (alloc_acc) begin
        rob_d[tail_q].valid    = 1'b1;
        rob_d[tail_q].done     = 1'b0;
        rob_d[tail_q].rd       = in_alloc_rd;
        rob_d[tail_q].is_store = in_alloc_is_store;
        rob_d[tail_q].pc       = in_alloc_PC;
        rob_d[tail_q].exc      = 3'd0;
        tail_d                 = tail_q + IDX_W'(1);
      end
      count_d = count_q + (IDX_W+1)'(alloc_acc) - (IDX_W+1)'(ret_norm);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_ENTRIES; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_ENTRIES; i++) rob_q[i] <= rob_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer. The driver keeps a program-order queue
// of live instructions as its reference and pushes expected status and
// retire events; an independent monitor pops and compares on the falling edge.
module tb_reorder_buffer;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_allocate = 1'b0;
  logic [4:0]    in_alloc_rd = '0;
  logic          in_alloc_is_store = 1'b0;
  logic [DW-1:0] in_alloc_PC = '0;
  logic [IW-1:0] out_alloc_idx;
  logic          out_full;
  logic          in_complete = 1'b0;
  logic [IW-1:0] in_complete_idx = '0;
  logic [DW-1:0] in_complete_data = '0;
  logic [2:0]    in_complete_exception = '0;
  logic          in_flush = 1'b0;
  logic          out_write_enable;
  logic [4:0]    out_write_reg;
  logic [DW-1:0] out_write_data;
  logic          out_store_commit;
  logic          out_exception;
  logic [2:0]    out_exception_vector;
  logic [DW-1:0] out_exception_PC;
  logic [IW:0]   out_count;

  reorder_buffer #(.ROB_ENTRIES(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_allocate(in_allocate), .in_alloc_rd(in_alloc_rd),
    .in_alloc_is_store(in_alloc_is_store), .in_alloc_PC(in_alloc_PC),
    .out_alloc_idx(out_alloc_idx), .out_full(out_full),
    .in_complete(in_complete), .in_complete_idx(in_complete_idx),
    .in_complete_data(in_complete_data), .in_complete_exception(in_complete_exception),
    .in_flush(in_flush),
    .out_write_enable(out_write_enable), .out_write_reg(out_write_reg),
    .out_write_data(out_write_data), .out_store_commit(out_store_commit),
    .out_exception(out_exception), .out_exception_vector(out_exception_vector),
    .out_exception_PC(out_exception_PC), .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Reference: live instructions, oldest first.
  typedef struct {
    int          idx;
    logic [4:0]  rd;
    bit          st;
    logic [31:0] pc;
    bit          done;
    logic [31:0] data;
    logic [2:0]  exc;
  } ment_t;

  typedef struct {
    int          cyc;
    bit          we;
    logic [4:0]  rg;
    logic [31:0] data;
    bit          sc;
    bit          ex;
    logic [2:0]  vec;
    logic [31:0] pc;
  } evt_t;

  typedef struct {
    int cnt;
    bit full;
    int aidx;
  } st_t;

  ment_t mq[$];
  evt_t  rq[$];
  st_t   sq[$];
  int    mhead = 0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // One clock cycle of stimulus: publish the expectations that follow from
  // the current reference state, drive inputs, then advance the reference.
  task automatic step(input bit a, input logic [4:0] rd, input bit st, input logic [31:0] pc,
                      input bit c, input logic [3:0] ci, input logic [31:0] cd,
                      input logic [2:0] ce, input bit f);
    int    sz, aidx;
    bit    retn, rete;
    evt_t  e;
    st_t   s;
    @(posedge clk); #1;
    cyc++;
    sz   = mq.size();
    aidx = (mhead + sz) % N;
    s.cnt = sz; s.full = (sz == N); s.aidx = aidx;
    sq.push_back(s);
    retn = 0; rete = 0;
    if (sz > 0 && mq[0].done) begin
      rete   = (mq[0].exc != 0);
      retn   = !rete;
      e.cyc  = cyc;
      e.we   = retn && !mq[0].st && (mq[0].rd != 0);
      e.rg   = mq[0].rd;
      e.data = mq[0].data;
      e.sc   = retn && mq[0].st;
      e.ex   = rete;
      e.vec  = mq[0].exc;
      e.pc   = mq[0].pc;
      if (e.we || e.sc || e.ex) rq.push_back(e);
    end
    in_allocate = a; in_alloc_rd = rd; in_alloc_is_store = st; in_alloc_PC = pc;
    in_complete = c; in_complete_idx = ci; in_complete_data = cd;
    in_complete_exception = ce; in_flush = f;
    if (f || rete) begin
      mq.delete();
      mhead = 0;
    end else begin
      if (c) foreach (mq[i]) if (mq[i].idx == int'(ci)) begin
        mq[i].done = 1; mq[i].data = cd; mq[i].exc = ce;
      end
      if (retn) begin
        void'(mq.pop_front());
        mhead = (mhead + 1) % N;
      end
      if (a && sz < N) begin
        ment_t m;
        m.idx = aidx; m.rd = rd; m.st = st; m.pc = pc;
        m.done = 0; m.data = 0; m.exc = 0;
        mq.push_back(m);
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic alloc(input logic [4:0] rd, input bit st, input logic [31:0] pc);
    step(1, rd, st, pc, 0, 0, 0, 0, 0);
  endtask
  task automatic comp(input logic [3:0] ci, input logic [31:0] cd, input logic [2:0] ce);
    step(0, 0, 0, 0, 1, ci, cd, ce, 0);
  endtask
  task automatic flush();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [84:0] all_outs();
    return {out_alloc_idx, out_full, out_write_enable, out_write_reg, out_write_data,
            out_store_commit, out_exception, out_exception_vector, out_exception_PC, out_count};
  endfunction

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic reset_mid(input string name);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (all_outs() != '0) begin
      errors++;
      $display("FAIL %s outputs got %h exp 0", name, all_outs());
    end
    in_allocate = 0; in_complete = 0; in_flush = 0;
    mq.delete();
    mhead = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Monitor: status every cycle, retire events whenever the DUT shows one.
  st_t  ms;
  evt_t me;
  initial forever begin
    @(negedge clk);
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      checks++;
      if (int'(out_count) != ms.cnt || out_full != ms.full || int'(out_alloc_idx) != ms.aidx) begin
        errors++;
        $display("FAIL status cyc=%0d count got %0d exp %0d full got %0b exp %0b alloc_idx got %0d exp %0d",
                 cyc, out_count, ms.cnt, out_full, ms.full, out_alloc_idx, ms.aidx);
      end
    end
    if (out_write_enable || out_store_commit || out_exception) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected cyc=%0d we=%0b sc=%0b ex=%0b exp none",
                 cyc, out_write_enable, out_store_commit, out_exception);
      end else begin
        me = rq.pop_front();
        if (me.cyc != cyc || out_write_enable != me.we || out_store_commit != me.sc ||
            out_exception != me.ex ||
            (me.we && (out_write_reg != me.rg || out_write_data != me.data)) ||
            (me.ex && (out_exception_vector != me.vec || out_exception_PC != me.pc))) begin
          errors++;
          $display("FAIL retire cyc got %0d exp %0d we %0b/%0b reg %0d/%0d data %h/%h sc %0b/%0b ex %0b/%0b vec %0d/%0d pc %h/%h (got/exp)",
                   cyc, me.cyc, out_write_enable, me.we, out_write_reg, me.rg,
                   out_write_data, me.data, out_store_commit, me.sc, out_exception, me.ex,
                   out_exception_vector, me.vec, out_exception_PC, me.pc);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    checks++;
    if (all_outs() != '0) begin
      errors++;
      $display("FAIL reset_state outputs got %h exp 0", all_outs());
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Single write-back
    alloc(5, 0, 32'h1000);
    comp(0, 32'hDEADBEEF, 0);
    idle(); idle();

    // Out-of-order completion, in-order retirement
    flush();
    alloc(1, 0, 32'h10); alloc(2, 0, 32'h14); alloc(3, 0, 32'h18);
    comp(2, 32'h33, 0); comp(0, 32'h11, 0); comp(1, 32'h22, 0);
    repeat (4) idle();

    // Fill, overflow attempt, retire one, wrap-around allocate
    flush();
    for (int i = 0; i < 17; i++) alloc(5'(i + 1), 0, 32'(i * 4));
    comp(0, 32'hA0, 0);
    idle();
    alloc(20, 0, 32'h200);
    for (int i = 1; i < 16; i++) comp(4'(i), 32'(i), 0);
    comp(0, 32'hB0, 0);
    repeat (18) idle();

    // Store then register write
    flush();
    alloc(9, 1, 32'h300); alloc(7, 0, 32'h304);
    comp(0, 32'h0, 0); comp(1, 32'h77, 0);
    repeat (3) idle();

    // Exception retire flushes
    flush();
    alloc(4, 0, 32'h100); alloc(6, 0, 32'h104);
    comp(0, 32'h55, 3);
    idle(); idle();

    // Flush in the same cycle as a normal retirement keeps the write
    alloc(8, 0, 32'h400); alloc(9, 0, 32'h404);
    comp(0, 32'h88, 0);
    flush();
    idle();

    // Asynchronous reset with live entries; flush beats allocate
    for (int i = 0; i < 4; i++) alloc(5'(i + 10), 0, 32'(i));
    comp(1, 32'h1, 0);
    reset_mid("reset_mid");
    idle();
    alloc(3, 0, 32'h500);
    step(1, 12, 0, 32'h504, 0, 0, 0, 0, 1);
    idle(); idle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit          a, c, f;
      logic [3:0]  ci;
      logic [2:0]  ce;
      a  = ($urandom_range(9) < 6);
      c  = ($urandom_range(1) == 1);
      f  = ($urandom_range(49) == 0);
      ce = ($urandom_range(19) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
      if (mq.size() > 0 && $urandom_range(7) != 0)
        ci = 4'(mq[$urandom_range(mq.size() - 1)].idx);
      else
        ci = 4'($urandom);
      step(a, 5'($urandom), ($urandom_range(3) == 0), $urandom, c, ci, $urandom, ce, f);
    end

    // Drain whatever is still live
    for (int n = 0; n < 60; n++) begin
      int k;
      k = -1;
      foreach (mq[i]) if (k < 0 && !mq[i].done) k = i;
      if (k >= 0) comp(4'(mq[k].idx), 32'(n), 0);
      else idle();
    end
    @(negedge clk); #1;
    checks++;
    if (rq.size() != 0 || mq.size() != 0) begin
      errors++;
      $display("FAIL drain pending retire events got %0d exp 0 live %0d", rq.size(), mq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
